// File: rtl/fifo4_drain.sv
// fifo4_drain: clocked read-side controller for the 4-entry strobe FIFO.
// Optional word counter enabled with `define FIFO4_DRAIN_CNT_EN.
//
// Ports:
//   clk, clrn           clock (rising edge), async active-low reset
//   enable              allow a new transfer to start (sampled in IDLE)
//   fifo_empty          FIFO empty flag, asynchronous to clk
//   fifo_dout           FIFO head word
//   fifo_read           registered pop strobe, PULSE_CYC cycles wide
//   out_data/out_valid  captured word and its valid flag
//   out_ready           consumer accept
//   busy                controller not idle
//   drained_cnt         delivered word count (0 when counter disabled)
module fifo4_drain #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE_CYC  = 1,
   parameter int PULSE_CYC   = 2
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_read,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [15:0]      drained_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      POP,
      GAP,
      HOLD
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYC - 1);
   localparam logic [3:0] GAP_LAST    = 4'(SYNC_STAGES);

   state_t state_q, state_n;
   logic [3:0] cnt_q, cnt_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic empty_s;
   logic hs;

   assign empty_s = sync_q[SYNC_STAGES-1];
   assign hs      = out_valid & out_ready;
   assign busy    = (state_q != IDLE);

   // Reset to all-ones so the flag reads empty until really sampled.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], fifo_empty};
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (enable && !empty_s) begin
               state_n = SETTLE;
               cnt_n   = '0;
            end
         end
         SETTLE: begin
            if (empty_s) begin
               state_n = IDLE;
            end else if (cnt_q == SETTLE_LAST) begin
               state_n = CAPTURE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 4'd1;
            end
         end
         CAPTURE: begin
            state_n = POP;
            cnt_n   = '0;
         end
         POP: begin
            if (cnt_q == PULSE_LAST) begin
               state_n = GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 4'd1;
            end
         end
         GAP: begin
            // Skip HOLD if the word was already taken during POP/GAP.
            if (cnt_q == GAP_LAST) begin
               state_n = (out_valid && !out_ready) ? HOLD : IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 4'd1;
            end
         end
         HOLD: begin
            if (hs) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fifo_read <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         // Strobe follows the next state so it is a clean flop output.
         fifo_read <= (state_n == POP);
         if (state_q == CAPTURE) begin
            out_valid <= 1'b1;
            out_data  <= fifo_dout;
         end else if (hs) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef FIFO4_DRAIN_CNT_EN
   logic [15:0] drained_q;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         drained_q <= '0;
      end else if (hs) begin
         drained_q <= drained_q + 16'd1;
      end
   end

   assign drained_cnt = drained_q;
`else
   assign drained_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo4_drain.sv
// tb_fifo4_drain: randomized scoreboard bench for fifo4_drain.
// Behavioural 4-entry FIFO and word-order model live in the bench.
module tb_fifo4_drain;

   localparam int W     = 8;
   localparam int PULSE = 2;

   logic          clk;
   logic          clrn;
   logic          enable;
   logic          fifo_empty;
   logic [W-1:0]  fifo_dout;
   logic          fifo_read;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic [15:0]   drained_cnt;

   fifo4_drain #(
      .WIDTH(W), .SYNC_STAGES(2), .SETTLE_CYC(1), .PULSE_CYC(PULSE)
   ) dut (
      .clk(clk),
      .clrn(clrn),
      .enable(enable),
      .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout),
      .fifo_read(fifo_read),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .drained_cnt(drained_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FIFO: words written so far, words popped so far.
   logic [W-1:0] mem [256];
   int  nwr;
   int  npop;
   int  pop_empty;
   logic glitch;

   assign fifo_empty = (nwr == npop) && !glitch;
   assign fifo_dout  = mem[8'(npop)];

   always @(posedge fifo_read) begin
      if (nwr != npop) npop++;
      else pop_empty++;
   end

   int nchk;
   int nerr;
   logic [W-1:0] exp_q [$];
   int  taken;
   int  lost;
   int  rdy_mode;
   int  mdl_cnt;
   int  run;
   logic prev_v;
   logic prev_hs;
   logic [W-1:0] prev_d;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_ready();
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom % 2);
         endcase
      end
   endtask

   task automatic monitor();
      logic [W-1:0] e;
      logic [15:0]  ce;
      forever begin
         @(negedge clk);
         if (!clrn) begin
            // Popped but undelivered words are discarded by reset.
            while (taken < npop) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               taken++;
               lost++;
            end
            mdl_cnt = 0;
            run     = 0;
            prev_v  = 1'b0;
            prev_hs = 1'b0;
         end else begin
            if (prev_v && !prev_hs && out_valid)
               chk("data_stable", 32'(out_data), 32'(prev_d));
            if (out_valid && out_ready) begin
`ifdef FIFO4_DRAIN_CNT_EN
               ce = 16'(mdl_cnt);
`else
               ce = 16'h0000;
`endif
               chk("drained_cnt", 32'(drained_cnt), 32'(ce));
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", 32'(out_data), 32'hffff_ffff);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", 32'(out_data), 32'(e));
               end
               mdl_cnt++;
               taken++;
            end
            if (fifo_read) begin
               run++;
            end else if (run != 0) begin
               chk("pulse_width", 32'(run), 32'(PULSE));
               run = 0;
            end
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
            prev_d  = out_data;
         end
      end
   endtask

   task automatic write_word(input logic [W-1:0] d, input int maxdly);
      int g;
      g = 0;
      while ((nwr - npop) >= 4 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (g >= 300) chk("fifo_space_timeout", 32'(g), 32'd0);
      #($urandom_range(0, maxdly));
      mem[8'(nwr)] = d;
      exp_q.push_back(d);
      nwr++;
   endtask

   task automatic wait_drain(input int maxc, input string nm);
      int g;
      g = 0;
      while (!(taken == nwr && !busy) && g < maxc) begin
         @(negedge clk);
         g++;
      end
      if (g >= maxc) chk(nm, 32'(taken), 32'(nwr));
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_sig(input int which, input string nm);
      int g;
      g = 0;
      while (!((which == 0) ? out_valid : fifo_read) && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) chk(nm, 32'(g), 32'd0);
   endtask

   initial begin
      int p0;
      int t0;
      logic [W-1:0] d1;
      logic [15:0] ce;
      nwr = 0; npop = 0; pop_empty = 0; glitch = 1'b0;
      nchk = 0; nerr = 0; taken = 0; lost = 0; mdl_cnt = 0; run = 0;
      prev_v = 1'b0; prev_hs = 1'b0; prev_d = '0;
      rdy_mode = 0; out_ready = 1'b0; enable = 1'b1; clrn = 1'b0;
      fork
         drive_ready();
         monitor();
      join_none

      // Reset with a word already waiting.
      mem[0] = 8'hA5; exp_q.push_back(8'hA5); nwr = 1;
      repeat (2) @(negedge clk);
      chk("rst_fifo_read", 32'(fifo_read), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_drained", 32'(drained_cnt), 32'd0);
      clrn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #2;
         chk("latency_not_yet", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #2;
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_data", 32'(out_data), 32'hA5);
      rdy_mode = 1;
      wait_drain(200, "drain_first");

      // Burst of four words, consumer always ready.
      p0 = npop;
      for (int i = 0; i < 4; i++) write_word(8'hE1 + 8'(i), 3);
      wait_drain(300, "drain_burst");
      chk("burst_pops", 32'(npop - p0), 32'd4);
      chk("burst_idle_read", 32'(fifo_read), 32'd0);

      // Backpressure for 20 cycles on the first word.
      rdy_mode = 0;
      d1 = 8'h3C;
      write_word(d1, 3);
      write_word(8'hC3, 3);
      wait_sig(0, "bp_valid_timeout");
      p0 = npop;
      repeat (20) @(negedge clk);
      chk("bp_no_pop", 32'(npop), 32'(p0));
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_data_held", 32'(out_data), 32'(d1));
      rdy_mode = 1;
      wait_drain(300, "drain_bp");

      // One-cycle empty glitch must be rejected.
      p0 = npop;
      @(posedge clk); #1;
      glitch = 1'b1;
      #10;
      glitch = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_no_pop", 32'(npop), 32'(p0));
      chk("glitch_no_valid", 32'(out_valid), 32'd0);
      chk("glitch_idle", 32'(busy), 32'd0);

      // enable=0 blocks start; dropping it mid-pop completes the word.
      enable = 1'b0;
      p0 = npop;
      write_word(8'h11, 3);
      write_word(8'h22, 3);
      repeat (20) @(negedge clk);
      chk("dis_no_pop", 32'(npop), 32'(p0));
      chk("dis_idle", 32'(busy), 32'd0);
      enable = 1'b1;
      t0 = taken;
      wait_sig(1, "en_pop_timeout");
      enable = 1'b0;
      repeat (30) @(negedge clk);
      chk("en_drop_one_word", 32'(taken - t0), 32'd1);
      chk("en_drop_one_pop", 32'(npop - p0), 32'd1);
      chk("en_drop_idle", 32'(busy), 32'd0);
      enable = 1'b1;
      wait_drain(300, "drain_en");

      // Reset in the middle of a pop loses only that word.
      rdy_mode = 0;
      t0 = lost;
      for (int i = 0; i < 3; i++) write_word(8'h70 + 8'(i), 3);
      wait_sig(1, "rst_pop_timeout");
      #2;
      clrn = 1'b0;
      #1;
      chk("rstpop_read", 32'(fifo_read), 32'd0);
      chk("rstpop_valid", 32'(out_valid), 32'd0);
      chk("rstpop_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      clrn = 1'b1;
      rdy_mode = 1;
      wait_drain(400, "drain_rst");
      chk("rst_lost", 32'(lost - t0), 32'd1);

      // Randomized traffic and consumer.
      rdy_mode = 2;
      for (int i = 0; i < 30; i++) write_word(8'($urandom), 40);
      wait_drain(2000, "drain_random");

`ifdef FIFO4_DRAIN_CNT_EN
      ce = 16'(mdl_cnt);
`else
      ce = 16'h0000;
`endif
      chk("final_drained", 32'(drained_cnt), 32'(ce));
      chk("final_all_popped", 32'(npop), 32'(nwr));
      chk("final_all_taken", 32'(taken), 32'(nwr));
      chk("pop_on_empty", 32'(pop_empty), 32'd0);
      chk("final_idle", 32'(busy), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
